hazard3_eth_mii_rx: RTL

//  MII receive deframer: the wire-side counterpart of the ethernet TX frame buffer.
//  - Strips preamble/SFD and packs MII nibbles into bytes.
//  - Writes each byte into the rx frame buffer's byte write port.
//  - Reports frame length/status and holds the frame until the host releases it.
//  - Sits between the MII pins (already synchronised into clk) and the APB ethernet peripheral.

---
 rtl/hazard3_eth_mii_rx_if.sv | 54 +++++
 rtl/hazard3_eth_mii_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_eth_mii_rx_if.sv
// ---------------------------------------------------------------------------
// hazard3_eth_mii_rx_if
// Bundles the MII receive pins, the rx frame buffer byte write port and the
// host status/release signals of the MII receive deframer.
//
//   master : deframer side (samples MII + release, drives buffer and status)
//   slave  : environment side (drives MII + release, observes buffer/status)
//
// Signals
//   rx_ce        1       one-clk strobe per MII nibble time
//   rx_dv        1       MII receive data valid
//   rx_er        1       MII receive error
//   rxd          4       MII nibble, low nibble of each byte first
//   wr_en        1       buffer byte write strobe
//   wr_addr      ADDR_W  buffer byte address
//   wr_data      8       buffer byte data
//   rx_release   1       host pulse: frame consumed, buffer free
//   frame_valid  1       a completed frame is held in the buffer
//   frame_len    16      byte count of held frame incl. FCS
//   frame_err    1       held frame is bad
//   crc_err      1       held frame failed FCS check
//   drop_cnt     16      frames discarded because the buffer was full
//   busy         1       deframer not idle
// ---------------------------------------------------------------------------
interface hazard3_eth_mii_rx_if #(
    parameter int ADDR_W = 11
);
    logic              rx_ce;
    logic              rx_dv;
    logic              rx_er;
    logic [3:0]        rxd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rx_release;
    logic              frame_valid;
    logic [15:0]       frame_len;
    logic              frame_err;
    logic              crc_err;
    logic [15:0]       drop_cnt;
    logic              busy;

    modport master (
        input  rx_ce, rx_dv, rx_er, rxd, rx_release,
        output wr_en, wr_addr, wr_data, frame_valid, frame_len,
               frame_err, crc_err, drop_cnt, busy
    );

    modport slave (
        output rx_ce, rx_dv, rx_er, rxd, rx_release,
        input  wr_en, wr_addr, wr_data, frame_valid, frame_len,
               frame_err, crc_err, drop_cnt, busy
    );
endinterface

// File: rtl/hazard3_eth_mii_rx.sv
// ---------------------------------------------------------------------------
// hazard3_eth_mii_rx
// MII receive deframer. Strips preamble/SFD, packs nibbles into bytes, writes
// each byte into the rx frame buffer and reports length/status of the frame,
// holding it until the host pulses rx_release.
//
// Build option
//   ETH_RX_CRC_CHECK_EN : when defined, a reflected CRC-32 runs over every
//                         received byte (FCS included) and crc_err reports a
//                         residue mismatch. When undefined no CRC logic is
//                         built and crc_err is tied low.
//
// Parameters
//   MTU      rx buffer size in bytes; longer frames are truncated and flagged
//   ADDR_W   buffer address width (2**ADDR_W must be >= MTU)
//   MIN_LEN  minimum legal frame length incl. FCS
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    hazard3_eth_mii_rx_if.master (MII in, buffer write, host status)
// ---------------------------------------------------------------------------
module hazard3_eth_mii_rx #(
    parameter int MTU     = 1536,
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard3_eth_mii_rx_if.master  bus
);

    localparam logic [15:0] MTU_L     = 16'(MTU);
    localparam logic [15:0] MIN_LEN_L = 16'(MIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_DONE,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_next;

    // FSM strobes consumed by the datapath
    logic w_start;      // SFD accepted, new frame begins
    logic w_drop_hit;   // SFD seen while buffer still held
    logic w_nib_lo;     // low nibble of a byte captured
    logic w_byte_done;  // high nibble completes a byte

    // Frame assembly state
    logic [15:0]       r_cnt;     // bytes received, saturates at MTU
    logic              r_phase;   // 1 = low nibble held, waiting for high
    logic [3:0]        r_lo;
    logic              r_err;     // sticky rx_er seen during data
    logic              r_ovf;     // bytes arrived after buffer was full

    // Output registers
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_frame_valid;
    logic [15:0]       r_frame_len;
    logic              r_frame_err;
    logic [15:0]       r_drop_cnt;

    logic [7:0]        w_byte;
    assign w_byte = {bus.rxd, r_lo};

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // -----------------------------------------------------------------------
    // FSM next state. IDLE evaluates its first nibble exactly like PRE so that
    // an SFD arriving with no preamble at all still starts a frame.
    // A release arriving together with the SFD frees the buffer in time for
    // that SFD, so the new frame is accepted rather than dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_drop_hit  = 1'b0;
        w_nib_lo    = 1'b0;
        w_byte_done = 1'b0;
        case (r_state)
            S_IDLE, S_PRE: begin
                if (bus.rx_ce) begin
                    if (!bus.rx_dv) begin
                        w_next = S_IDLE;
                    end else if (bus.rxd == 4'h5) begin
                        w_next = S_PRE;
                    end else if (bus.rxd == 4'hD) begin
                        if (!r_frame_valid || bus.rx_release) begin
                            w_next  = S_DATA;
                            w_start = 1'b1;
                        end else begin
                            w_next     = S_DROP;
                            w_drop_hit = 1'b1;
                        end
                    end else begin
                        w_next = S_DROP;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_ce) begin
                    if (!bus.rx_dv)    w_next      = S_DONE;
                    else if (!r_phase) w_nib_lo    = 1'b1;
                    else               w_byte_done = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            S_DROP: begin
                if (bus.rx_ce && !bus.rx_dv) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Byte assembly and buffer write. The write strobe is a single-cycle
    // registered pulse one clk after the completing nibble is sampled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_lo      <= '0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
                r_err   <= 1'b0;
                r_ovf   <= 1'b0;
            end
            if (w_nib_lo) begin
                r_lo    <= bus.rxd;
                r_phase <= 1'b1;
            end
            if (w_byte_done) begin
                r_phase <= 1'b0;
                if (r_cnt < MTU_L) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_cnt[ADDR_W-1:0];
                    r_wr_data <= w_byte;
                    r_cnt     <= r_cnt + 16'd1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            // rx_er only counts while the nibble is part of the frame
            if (r_state == S_DATA && bus.rx_ce && bus.rx_dv && bus.rx_er)
                r_err <= 1'b1;
        end
    end

`ifdef ETH_RX_CRC_CHECK_EN
    // Reflected CRC-32, one byte per call, no final inversion: running it
    // over the FCS too leaves the fixed residue 0xDEBB20E3 on a good frame.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] c,
                                               input logic [7:0]  b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    logic [31:0] r_crc;
    logic        r_crc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (w_start) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (w_byte_done) begin
            // bytes past MTU still feed the CRC; the verdict is forced anyway
            r_crc <= f_crc_byte(r_crc, w_byte);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Frame status / hold / drop counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_valid <= 1'b0;
            r_frame_len   <= '0;
            r_frame_err   <= 1'b0;
            r_drop_cnt    <= '0;
`ifdef ETH_RX_CRC_CHECK_EN
            r_crc_err     <= 1'b0;
`endif
        end else begin
            if (bus.rx_release) begin
                r_frame_valid <= 1'b0;
                r_frame_err   <= 1'b0;
`ifdef ETH_RX_CRC_CHECK_EN
                r_crc_err     <= 1'b0;
`endif
            end
            if (r_state == S_DONE) begin
                r_frame_valid <= 1'b1;
                r_frame_len   <= r_cnt;
                // r_phase still set means the frame ended on a lone nibble
                r_frame_err   <= r_err | r_phase | r_ovf | (r_cnt < MIN_LEN_L);
`ifdef ETH_RX_CRC_CHECK_EN
                r_crc_err     <= r_ovf | (r_crc != 32'hDEBB20E3);
`endif
            end
            if (w_drop_hit)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.wr_en       = r_wr_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_len   = r_frame_len;
    assign bus.frame_err   = r_frame_err;
    assign bus.drop_cnt    = r_drop_cnt;
    assign bus.busy        = (r_state != S_IDLE);
`ifdef ETH_RX_CRC_CHECK_EN
    assign bus.crc_err     = r_crc_err;
`else
    assign bus.crc_err     = 1'b0;
`endif

endmodule
